lut_burst_loader: RTL and testbench

Staging loader directly upstream of the log-domain FP16 multiplier's LUT write port. A host fills a 128-entry staging buffer of {log2 mantissa, exp2 FP16} pairs at its own pace over a valid/ready handshake. The block then replays the whole table as one gap-free burst on `lut_wr_en` / `log2_lut_data_out` / `exp2_lut_data_out`, because the multiplier captures entries sequentially and cannot tolerate bubbles. After the burst it flags `lut_loaded`, which gates operand issue to the multiplier.

---
 rtl/lut_burst_loader.sv | 114 +++++++++++
 tb/tb_lut_burst_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lut_burst_loader.sv
// Staging buffer for the log-domain multiplier LUTs: the host fills it at its own pace,
// then the whole table is replayed as one gap-free write burst.
module lut_burst_loader #(
   parameter int LUT_SIZE  = 128,
   parameter int MANT_LEN  = 10,
   parameter int FLOAT_LEN = 16,
   parameter int IDX_W     = $clog2(LUT_SIZE)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 host_valid,
   output logic                 host_ready,
   input  logic [MANT_LEN-1:0]  host_log2_data,
   input  logic [FLOAT_LEN-1:0] host_exp2_data,
   input  logic                 reload,
   output logic                 lut_wr_en,
   output logic [MANT_LEN-1:0]  log2_lut_data_out,
   output logic [FLOAT_LEN-1:0] exp2_lut_data_out,
   output logic                 busy,
   output logic                 lut_loaded
);
   localparam int CNT_W = IDX_W + 1;
   localparam int ENT_W = MANT_LEN + FLOAT_LEN;

   localparam logic [1:0] S_FILL  = 2'd0;
   localparam logic [1:0] S_BURST = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LUT_SIZE - 1);
   localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(LUT_SIZE);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
   logic             host_ready_q;
   logic             lut_wr_en_q, lut_wr_en_d;
   logic [ENT_W-1:0] lut_buf [LUT_SIZE];
   logic [ENT_W-1:0] rd_data_q;
   logic             accept;
   logic             emit;

   // reload outranks a coinciding handshake, so the entry is dropped
   assign accept = host_valid && host_ready_q && (state_q == S_FILL) && !reload;
   // rd_cnt parks at LUT_SIZE after the last beat; that cycle is the move to DONE
   assign emit   = (state_q == S_BURST) && (rd_cnt_q != CNT_END);

   always_comb begin
      state_d     = state_q;
      wr_cnt_d    = wr_cnt_q;
      rd_cnt_d    = rd_cnt_q;
      lut_wr_en_d = 1'b0;
      case (state_q)
         S_FILL: begin
            if (reload) begin
               wr_cnt_d = '0;
            end else if (accept) begin
               wr_cnt_d = wr_cnt_q + CNT_ONE;
               if (wr_cnt_q == CNT_LAST) begin
                  state_d  = S_BURST;
                  rd_cnt_d = '0;
               end
            end
         end
         S_BURST: begin
            if (emit) begin
               lut_wr_en_d = 1'b1;
               rd_cnt_d    = rd_cnt_q + CNT_ONE;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (reload) begin
               state_d  = S_FILL;
               wr_cnt_d = '0;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_FILL;
         wr_cnt_q     <= '0;
         rd_cnt_q     <= '0;
         host_ready_q <= 1'b0;
         lut_wr_en_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         wr_cnt_q     <= wr_cnt_d;
         rd_cnt_q     <= rd_cnt_d;
         host_ready_q <= (state_d == S_FILL);
         lut_wr_en_q  <= lut_wr_en_d;
      end
   end

   // Block-RAM style storage: no reset, registered read
   always_ff @(posedge clk) begin
      if (accept) begin
         lut_buf[wr_cnt_q[IDX_W-1:0]] <= {host_log2_data, host_exp2_data};
      end
      rd_data_q <= lut_buf[rd_cnt_q[IDX_W-1:0]];
   end

   assign host_ready        = host_ready_q;
   assign lut_wr_en         = lut_wr_en_q;
   assign log2_lut_data_out = lut_wr_en_q ? rd_data_q[ENT_W-1:FLOAT_LEN] : '0;
   assign exp2_lut_data_out = lut_wr_en_q ? rd_data_q[FLOAT_LEN-1:0] : '0;
   assign busy              = (state_q == S_BURST);
   assign lut_loaded        = (state_q == S_DONE);

endmodule

// File: tb/tb_lut_burst_loader.sv
// Directed bench for lut_burst_loader: fills, bursts, reloads and a reset in mid-burst.
module tb_lut_burst_loader;
   localparam int LUT_SIZE  = 128;
   localparam int MANT_LEN  = 10;
   localparam int FLOAT_LEN = 16;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic                 host_valid;
   logic                 host_ready;
   logic [MANT_LEN-1:0]  host_log2_data;
   logic [FLOAT_LEN-1:0] host_exp2_data;
   logic                 reload;
   logic                 lut_wr_en;
   logic [MANT_LEN-1:0]  log2_lut_data_out;
   logic [FLOAT_LEN-1:0] exp2_lut_data_out;
   logic                 busy;
   logic                 lut_loaded;

   int total = 0;
   int bad   = 0;

   logic [MANT_LEN-1:0]  exp_log2 [LUT_SIZE];
   logic [FLOAT_LEN-1:0] exp_exp2 [LUT_SIZE];

   lut_burst_loader #(
      .LUT_SIZE (LUT_SIZE),
      .MANT_LEN (MANT_LEN),
      .FLOAT_LEN(FLOAT_LEN)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .host_valid       (host_valid),
      .host_ready       (host_ready),
      .host_log2_data   (host_log2_data),
      .host_exp2_data   (host_exp2_data),
      .reload           (reload),
      .lut_wr_en        (lut_wr_en),
      .log2_lut_data_out(log2_lut_data_out),
      .exp2_lut_data_out(exp2_lut_data_out),
      .busy             (busy),
      .lut_loaded       (lut_loaded)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_wr_en"}, 32'(lut_wr_en), 32'd0);
      chk({tag, "_log2"}, 32'(log2_lut_data_out), 32'd0);
      chk({tag, "_exp2"}, 32'(exp2_lut_data_out), 32'd0);
   endtask

   // Sends entries 0..n-1 from the expected tables; optionally idles every third cycle
   task automatic send(input int n, input bit gapped);
      int c = 0;
      for (int k = 0; k < n; k++) begin
         if (gapped && (c % 3 == 2)) begin
            host_valid = 1'b0;
            step();
            c++;
         end
         host_valid     = 1'b1;
         host_log2_data = exp_log2[k];
         host_exp2_data = exp_exp2[k];
         chk("fill_ready", 32'(host_ready), 32'd1);
         step();
         c++;
      end
   endtask

   // Called right after the edge that accepted the last entry
   task automatic burst(input string tag, input int reload_beat, input int reset_beat, input bit stall);
      chk({tag, "_e_ready"}, 32'(host_ready), 32'd0);
      chk({tag, "_e_busy"}, 32'(busy), 32'd1);
      chk({tag, "_e_bubble"}, 32'(lut_wr_en), 32'd0);
      host_valid = stall;
      for (int b = 0; b < LUT_SIZE; b++) begin
         if (stall) begin
            host_log2_data = MANT_LEN'($urandom);
            host_exp2_data = FLOAT_LEN'($urandom);
         end
         reload = (b == reload_beat);
         step();
         chk({tag, "_beat_wr_en"}, 32'(lut_wr_en), 32'd1);
         chk({tag, "_beat_log2"}, 32'(log2_lut_data_out), 32'(exp_log2[b]));
         chk({tag, "_beat_exp2"}, 32'(exp2_lut_data_out), 32'(exp_exp2[b]));
         chk({tag, "_beat_ready"}, 32'(host_ready), 32'd0);
         chk({tag, "_beat_loaded"}, 32'(lut_loaded), 32'd0);
         if (b == reset_beat) begin
            reload     = 1'b0;
            host_valid = 1'b0;
            rst_n      = 1'b0;
            #1;
            chk_idle_outputs({tag, "_async_rst"});
            chk({tag, "_async_rst_busy"}, 32'(busy), 32'd0);
            chk({tag, "_async_rst_ready"}, 32'(host_ready), 32'd0);
            return;
         end
      end
      reload     = 1'b0;
      host_valid = 1'b0;
      step();
      chk_idle_outputs({tag, "_done"});
      chk({tag, "_done_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done_loaded"}, 32'(lut_loaded), 32'd1);
      chk({tag, "_done_ready"}, 32'(host_ready), 32'd0);
   endtask

   task automatic reload_in_done(input string tag);
      reload = 1'b1;
      step();
      reload = 1'b0;
      chk({tag, "_loaded"}, 32'(lut_loaded), 32'd0);
      chk({tag, "_ready"}, 32'(host_ready), 32'd1);
   endtask

   initial begin
      rst_n          = 1'b0;
      host_valid     = 1'b0;
      host_log2_data = '0;
      host_exp2_data = '0;
      reload         = 1'b0;
      #1;
      chk_idle_outputs("reset");
      chk("reset_ready", 32'(host_ready), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_loaded", 32'(lut_loaded), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      chk("pre_edge_ready", 32'(host_ready), 32'd0);
      step();
      chk("first_edge_ready", 32'(host_ready), 32'd1);

      // Table A, gapped fill, host keeps pushing while busy
      for (int k = 0; k < LUT_SIZE; k++) begin
         exp_log2[k] = MANT_LEN'(k);
         exp_exp2[k] = 16'h3C00 + FLOAT_LEN'(k);
      end
      send(LUT_SIZE, 1'b1);
      burst("gapped", -1, -1, 1'b1);
      // DONE holds with no reload
      step();
      chk("done_hold_loaded", 32'(lut_loaded), 32'd1);
      reload_in_done("reload_done");

      // Partial junk table, reload coinciding with a handshake, then table B
      for (int k = 0; k < LUT_SIZE; k++) begin
         exp_log2[k] = MANT_LEN'(k + 200);
         exp_exp2[k] = 16'h5555;
      end
      send(50, 1'b0);
      host_valid     = 1'b1;
      host_log2_data = 10'h2AA;
      host_exp2_data = 16'hDEAD;
      reload         = 1'b1;
      step();
      reload     = 1'b0;
      host_valid = 1'b0;
      chk("midfill_reload_ready", 32'(host_ready), 32'd1);
      for (int k = 0; k < LUT_SIZE; k++) begin
         exp_log2[k] = 10'h3FF - MANT_LEN'(k);
         exp_exp2[k] = 16'h4000 ^ FLOAT_LEN'(k * 5);
      end
      send(LUT_SIZE, 1'b0);
      burst("tableB_reload60", 60, -1, 1'b0);
      reload_in_done("reload_done2");

      // Table C, reset at beat 40
      for (int k = 0; k < LUT_SIZE; k++) begin
         exp_log2[k] = MANT_LEN'(k * 7);
         exp_exp2[k] = 16'hC000 | FLOAT_LEN'(k * 3);
      end
      send(LUT_SIZE, 1'b1);
      burst("rst_mid", -1, 40, 1'b0);
      step();
      chk("in_reset_ready", 32'(host_ready), 32'd0);
      rst_n = 1'b1;
      step();
      chk("post_rst_ready", 32'(host_ready), 32'd1);
      chk("post_rst_loaded", 32'(lut_loaded), 32'd0);
      chk_idle_outputs("post_rst");

      // Full resend after reset, stalled host during burst
      for (int k = 0; k < LUT_SIZE; k++) begin
         exp_log2[k] = MANT_LEN'(127 - k);
         exp_exp2[k] = 16'h1234 + FLOAT_LEN'(k * 257);
      end
      send(LUT_SIZE, 1'b0);
      burst("after_rst", -1, -1, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
